// File: rtl/ldpc_dvb_enc_p_acc_pkg.sv
// Shared DVB-S2 LDPC encoder types and constants.
package ldpc_dvb_enc_p_acc_pkg;

    localparam int cROW_W   = 9;
    localparam int cDAT_W   = 360;
    localparam int cRAM_LAT = 2;

    typedef logic [cROW_W-1:0] row_t;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

endpackage

// File: rtl/ldpc_dvb_enc_p_acc_dline.sv
// Valid-tagged payload delay line with clock enable; only the valid bits are cleared by reset.
module ldpc_dvb_enc_p_acc_dline #(
    parameter int pDEPTH = 2,
    parameter int pW     = 13
) (
    input  logic          iclk,
    input  logic          ireset,
    input  logic          iclkena,
    input  logic          ival,
    input  logic [pW-1:0] idat,
    output logic          oval,
    output logic [pW-1:0] odat,
    output logic          obusy
);

    logic [pDEPTH-1:0] val_sr;
    logic [pW-1:0]     dat_sr [pDEPTH];

    // shift the valid tags, cleared asynchronously
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            val_sr <= '0;
        end else if (iclkena) begin
            val_sr[0] <= ival;
            for (int unsigned i = 1; i < pDEPTH; i++) begin
                val_sr[i] <= val_sr[i-1];
            end
        end
    end

    // shift the payload alongside, never reset
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            dat_sr[0] <= idat;
            for (int unsigned i = 1; i < pDEPTH; i++) begin
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end

    assign oval  = val_sr[pDEPTH-1];
    assign odat  = dat_sr[pDEPTH-1];
    assign obusy = |val_sr;

endmodule

// File: rtl/ldpc_dvb_enc_p_acc.sv
// DVB-S2 IRA parity accumulator: reads raw parity rows and emits p_acc[r] = p_raw[r] ^ p_acc[r-1].
module ldpc_dvb_enc_p_acc
    import ldpc_dvb_enc_p_acc_pkg::*;
#(
    parameter int pROW_W   = cROW_W,
    parameter int pDAT_W   = cDAT_W,
    parameter int pRAM_LAT = cRAM_LAT
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              iread,
    input  logic [3:0]        istrb,
    input  logic [pROW_W-1:0] irow_idx,
    output logic              oram_read,
    output logic [pROW_W-1:0] oram_raddr,
    input  logic [pDAT_W-1:0] iram_rdata,
    output logic              oval,
    output logic [3:0]        ostrb,
    output logic [pROW_W-1:0] orow_idx,
    output logic [pDAT_W-1:0] odat,
    output logic              obusy
);

    localparam int cPAY_W = 4 + pROW_W;

    logic [3:0]        strb_s0;
    logic              dl_val;
    logic [cPAY_W-1:0] dl_dat;
    logic              dl_busy;
    strb_t             dl_strb;
    logic [pROW_W-1:0] dl_row;
    logic [pDAT_W-1:0] acc;
    logic [pDAT_W-1:0] acc_nxt;

    // stage 0: RAM read request flag
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oram_read <= 1'b0;
        end else if (iclkena) begin
            oram_read <= iread;
        end
    end

    // stage 0: RAM address and strobe capture
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            oram_raddr <= irow_idx;
            strb_s0    <= istrb;
        end
    end

    // strobe/row travel with the read so they line up with iram_rdata
    ldpc_dvb_enc_p_acc_dline #(
        .pDEPTH (pRAM_LAT),
        .pW     (cPAY_W)
    ) u_dline (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (oram_read),
        .idat    ({strb_s0, oram_raddr}),
        .oval    (dl_val),
        .odat    (dl_dat),
        .obusy   (dl_busy)
    );

    assign dl_strb = strb_t'(dl_dat[cPAY_W-1 -: 4]);
    assign dl_row  = dl_dat[pROW_W-1:0];

    // next accumulator value: sof restarts the chain
    always_comb begin
        acc_nxt = iram_rdata;
        if (!dl_strb.sof) begin
            acc_nxt = iram_rdata ^ acc;
        end
    end

    // output valid and strobe
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oval  <= 1'b0;
            ostrb <= '0;
        end else if (iclkena) begin
            oval <= dl_val;
            if (dl_val) begin
                ostrb <= dl_strb;
            end
        end
    end

    // accumulator doubles as the output word; holds across gaps
    always_ff @(posedge iclk) begin
        if (iclkena && dl_val) begin
            acc      <= acc_nxt;
            orow_idx <= dl_row;
        end
    end

    assign odat  = acc;
    assign obusy = iread | oram_read | dl_busy | oval;

`ifndef SYNTHESIS
    logic acc_seen;

    // remember whether any frame start has been accumulated since reset
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            acc_seen <= 1'b0;
        end else if (iclkena && dl_val && dl_strb.sof) begin
            acc_seen <= 1'b1;
        end
    end

    a_sof_first : assert property (@(posedge iclk) disable iff (ireset)
        (iclkena && dl_val && !dl_strb.sof) |-> acc_seen);
`endif

endmodule

// File: tb/tb_ldpc_dvb_enc_p_acc.sv
// Self-checking bench: four DUTs (pRAM_LAT 1..4) share one stimulus stream and one expected stream.
module tb_ldpc_dvb_enc_p_acc;

    localparam int RW = 9;
    localparam int DW = 360;
    localparam int NI = 4;
    localparam int QN = 256;

    typedef struct {
        logic [DW-1:0] dat;
        logic [3:0]    strb;
        logic [RW-1:0] row;
        int            stamp;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          rd;
        bit          ena;
        logic [3:0]  strb;
        int          row;
        logic [31:0] raw;
        logic [31:0] expd;
    } vec_t;

    logic          iclk = 1'b0;
    logic          ireset = 1'b0;
    logic          iclkena = 1'b1;
    logic          iread = 1'b0;
    logic [3:0]    istrb = '0;
    logic [RW-1:0] irow_idx = '0;

    logic [DW-1:0] mem [512];

    logic          oram_read_a [NI];
    logic [RW-1:0] raddr_a     [NI];
    logic          oval_a      [NI];
    logic [3:0]    ostrb_a     [NI];
    logic [RW-1:0] orow_a      [NI];
    logic [DW-1:0] odat_a      [NI];
    logic          obusy_a     [NI];

    int total = 0;
    int bad = 0;

    exp_t          expq [QN];
    int            wr_ptr = 0;
    int            rd_ptr [NI];
    int            ecnt = 0;
    bit            last_ena = 1'b1;
    bit            last_iread = 1'b0;
    bit            last_rd = 1'b0;
    logic [RW-1:0] last_row = '0;
    logic          prev_oval [NI];
    logic [DW-1:0] prev_dat  [NI];

    vec_t tbl [80];
    int   ntbl = 0;

    always #5 iclk = ~iclk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = g + 1;
        logic [DW-1:0] pipe [L];
        logic [DW-1:0] rdata;

        always @(posedge iclk) begin
            if (iclkena) begin
                pipe[0] <= mem[raddr_a[g]];
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign rdata = pipe[L-1];

        ldpc_dvb_enc_p_acc #(
            .pROW_W   (RW),
            .pDAT_W   (DW),
            .pRAM_LAT (L)
        ) u_dut (
            .iclk       (iclk),
            .ireset     (ireset),
            .iclkena    (iclkena),
            .iread      (iread),
            .istrb      (istrb),
            .irow_idx   (irow_idx),
            .oram_read  (oram_read_a[g]),
            .oram_raddr (raddr_a[g]),
            .iram_rdata (rdata),
            .oval       (oval_a[g]),
            .ostrb      (ostrb_a[g]),
            .orow_idx   (orow_a[g]),
            .odat       (odat_a[g]),
            .obusy      (obusy_a[g])
        );
    end

    task automatic chk(input bit ok, input string nm, input int g,
                       input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s lat=%0d got=%h want=%h", nm, g + 1, got, want);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < 12; i++) w = (w << 32) | DW'($urandom());
        return w;
    endfunction

    function automatic bit busy_any();
        bit b;
        b = 1'b0;
        for (int g = 0; g < NI; g++) b = b | (rd_ptr[g] != wr_ptr) | oval_a[g];
        return b;
    endfunction

    // Observe outputs produced by the previous posedge.
    task automatic mon();
        exp_t e;
        for (int g = 0; g < NI; g++) begin
            if (!last_ena) begin
                chk(oval_a[g] === prev_oval[g], "freeze_oval", g, DW'(oval_a[g]), DW'(prev_oval[g]));
                if (oval_a[g]) chk(odat_a[g] === prev_dat[g], "freeze_odat", g, odat_a[g], prev_dat[g]);
            end else begin
                chk(oram_read_a[g] === last_iread, "ram_read", g, DW'(oram_read_a[g]), DW'(last_iread));
                if (last_rd) chk(raddr_a[g] === last_row, "ram_raddr", g, DW'(raddr_a[g]), DW'(last_row));
                if (oval_a[g]) begin
                    chk(rd_ptr[g] != wr_ptr, "oval_expected", g, DW'(oval_a[g]), DW'(0));
                    if (rd_ptr[g] != wr_ptr) begin
                        e = expq[rd_ptr[g] % QN];
                        rd_ptr[g]++;
                        chk(odat_a[g] === e.dat, "odat", g, odat_a[g], e.dat);
                        chk(ostrb_a[g] === e.strb, "ostrb", g, DW'(ostrb_a[g]), DW'(e.strb));
                        chk(orow_a[g] === e.row, "orow_idx", g, DW'(orow_a[g]), DW'(e.row));
                        chk((ecnt - e.stamp) == g + 3, "latency", g, DW'(ecnt - e.stamp), DW'(g + 3));
                    end
                end
            end
            chk(obusy_a[g] === (last_iread | (rd_ptr[g] != wr_ptr) | oval_a[g]), "obusy", g,
                DW'(obusy_a[g]), DW'(last_iread | (rd_ptr[g] != wr_ptr) | oval_a[g]));
            prev_oval[g] = oval_a[g];
            prev_dat[g]  = odat_a[g];
        end
    endtask

    task automatic cyc(input bit rd, input bit ena, input logic [3:0] strb,
                       input int row, input logic [DW-1:0] expd);
        @(negedge iclk);
        mon();
        iread    = rd;
        iclkena  = ena;
        istrb    = strb;
        irow_idx = RW'(row);
        if (ena) begin
            if (rd) begin
                expq[wr_ptr % QN] = '{expd, strb, RW'(row), ecnt};
                wr_ptr++;
            end
            ecnt++;
        end
        last_ena   = ena;
        last_iread = rd;
        last_rd    = rd && ena;
        last_row   = RW'(row);
    endtask

    task automatic rst_now();
        iread   = 1'b0;
        iclkena = 1'b1;
        ireset  = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk(oval_a[g] === 1'b0, "rst_oval", g, DW'(oval_a[g]), DW'(0));
            chk(obusy_a[g] === 1'b0, "rst_obusy", g, DW'(obusy_a[g]), DW'(0));
            chk(oram_read_a[g] === 1'b0, "rst_ram_read", g, DW'(oram_read_a[g]), DW'(0));
            chk(ostrb_a[g] === 4'b0, "rst_ostrb", g, DW'(ostrb_a[g]), DW'(0));
            rd_ptr[g]    = wr_ptr;
            prev_oval[g] = 1'b0;
        end
        last_ena   = 1'b1;
        last_iread = 1'b0;
        last_rd    = 1'b0;
        @(negedge iclk);
        mon();
        ireset = 1'b0;
    endtask

    task automatic add(input bit rst, input bit rd, input bit ena, input logic [3:0] strb,
                       input int row, input logic [31:0] raw, input logic [31:0] expd);
        tbl[ntbl] = '{rst, rd, ena, strb, row, raw, expd};
        ntbl++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 1, 4'b0000, 0, 0, 0);
    endtask

    initial begin
        int base;
        int k;
        int n;
        bit ena;
        bit rd;
        logic [3:0] strb;
        logic [DW-1:0] macc;

        for (int g = 0; g < NI; g++) begin
            rd_ptr[g]    = 0;
            prev_oval[g] = 1'b0;
            prev_dat[g]  = '0;
        end
        for (int i = 0; i < 512; i++) mem[i] = '0;

        // 4-row contiguous frame
        add(0, 1, 1, 4'b1100, 0, 32'h1, 32'h1);
        add(0, 1, 1, 4'b0000, 1, 32'h2, 32'h3);
        add(0, 1, 1, 4'b0000, 2, 32'h4, 32'h7);
        add(0, 1, 1, 4'b0011, 3, 32'h8, 32'hF);
        idle(6);
        // single-row frame
        add(0, 1, 1, 4'b1111, 10, 32'hA5, 32'hA5);
        idle(6);
        // two back-to-back 2-row frames
        add(0, 1, 1, 4'b1100, 20, 32'h3, 32'h3);
        add(0, 1, 1, 4'b0011, 21, 32'h5, 32'h6);
        add(0, 1, 1, 4'b1100, 22, 32'h6, 32'h6);
        add(0, 1, 1, 4'b0011, 23, 32'h9, 32'hF);
        idle(6);
        // 4-row frame with a gap and clock-enable holes
        add(0, 1, 1, 4'b1100, 0, 32'h1, 32'h1);
        add(0, 1, 1, 4'b0000, 1, 32'h2, 32'h3);
        idle(3);
        add(0, 1, 1, 4'b0000, 2, 32'h4, 32'h7);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 4'b0011, 3, 32'h8, 32'hF);
        idle(2);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        idle(6);
        // reset two cycles after row1's read, then a fresh frame
        add(0, 1, 1, 4'b1100, 30, 32'h7, 32'h7);
        add(0, 1, 1, 4'b0000, 31, 32'h9, 32'hE);
        idle(1);
        add(1, 0, 1, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 4'b1100, 40, 32'h1, 32'h1);
        add(0, 1, 1, 4'b0011, 41, 32'h1, 32'h0);
        idle(8);

        #2;
        rst_now();

        for (int i = 0; i < ntbl; i++) begin
            if (tbl[i].rst) begin
                @(negedge iclk);
                mon();
                rst_now();
            end else begin
                if (tbl[i].rd) mem[tbl[i].row] = DW'(tbl[i].raw);
                cyc(tbl[i].rd, tbl[i].ena, tbl[i].strb, tbl[i].row, DW'(tbl[i].expd));
            end
        end

        // random 64-row frames, back to back, with random gaps and enable holes
        macc = '0;
        for (int f = 0; f < 2; f++) begin
            base = (f == 0) ? 100 : 300;
            k = 0;
            while (k < 64) begin
                ena  = ($urandom_range(0, 9) != 0);
                rd   = ($urandom_range(0, 4) != 0);
                strb = {k == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), k == 63};
                if (rd && ena) begin
                    mem[base + k] = rnd_word();
                    macc = (k == 0) ? mem[base + k] : (macc ^ mem[base + k]);
                    cyc(1'b1, 1'b1, strb, base + k, macc);
                    k++;
                end else begin
                    cyc(rd, ena, strb, base + k, '0);
                end
            end
        end

        n = 0;
        while (n < 60 && busy_any()) begin
            cyc(1'b0, 1'b1, 4'b0000, 0, '0);
            n++;
        end
        cyc(1'b0, 1'b1, 4'b0000, 0, '0);
        for (int g = 0; g < NI; g++) begin
            chk(rd_ptr[g] == wr_ptr, "drain", g, DW'(wr_ptr - rd_ptr[g]), DW'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
